// File: rtl/spi_master_adc.sv
// SPI master for a pair of serial 8-bit ADC slaves sharing one data line.
// Generates sclk and the chip selects, and extracts one sample per frame.
module spi_master_adc #(
    parameter int CLK_DIV    = 2,
    parameter int FRAME_BITS = 16,
    parameter int LEAD_BITS  = 3,
    parameter int DATA_W     = 8,
    parameter int CS_GAP     = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              sel,
    output logic              busy,
    output logic              sclk,
    output logic [1:0]        cs_n,
    input  logic              sdata,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_ch,
    output logic              rx_valid
);

    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(FRAME_BITS + 1);

    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);
    localparam logic [BW-1:0] BIT_END  = BW'(FRAME_BITS);
    localparam logic [BW-1:0] CAP_LO   = BW'(LEAD_BITS);
    localparam logic [BW-1:0] CAP_HI   = BW'(LEAD_BITS + DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [BW-1:0]     bit_cnt, bit_cnt_d;
    logic              sclk_d;
    logic [1:0]        cs_n_d;
    logic              busy_d;
    logic              sel_q, sel_d;
    logic [DATA_W-1:0] shreg, shreg_d;
    logic [DATA_W-1:0] rx_data_d;
    logic              rx_ch_d;
    logic              rx_valid_d;

    logic div_done;
    logic gap_done;
    logic capture;
    logic accept;

    assign div_done = (cnt == DIV_LAST);
    assign gap_done = (state == GAP) && (cnt == GAP_LAST);
    assign capture  = (bit_cnt >= CAP_LO) && (bit_cnt < CAP_HI);
    // The last gap cycle doubles as an idle slot so back-to-back frames
    // repeat every frame length plus CS_GAP.
    assign accept   = start && ((state == IDLE) || gap_done);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            sclk     <= 1'b1;
            cs_n     <= 2'b11;
            busy     <= 1'b0;
            sel_q    <= 1'b0;
            shreg    <= '0;
            rx_data  <= '0;
            rx_ch    <= 1'b0;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            bit_cnt  <= bit_cnt_d;
            sclk     <= sclk_d;
            cs_n     <= cs_n_d;
            busy     <= busy_d;
            sel_q    <= sel_d;
            shreg    <= shreg_d;
            rx_data  <= rx_data_d;
            rx_ch    <= rx_ch_d;
            rx_valid <= rx_valid_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        bit_cnt_d  = bit_cnt;
        sclk_d     = sclk;
        cs_n_d     = cs_n;
        busy_d     = busy;
        sel_d      = sel_q;
        shreg_d    = shreg;
        rx_data_d  = rx_data;
        rx_ch_d    = rx_ch;
        rx_valid_d = 1'b0;

        unique case (state)
            IDLE: ;
            SETUP: begin
                if (div_done) begin
                    state_d   = SHIFT;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    sclk_d    = 1'b0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (!div_done) begin
                    cnt_d = cnt + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (!sclk) begin
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt + 1'b1;
                        if (capture) begin
                            shreg_d = {shreg[DATA_W-2:0], sdata};
                        end
                    end else if (bit_cnt == BIT_END) begin
                        state_d = HOLD;
                    end else begin
                        sclk_d = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (div_done) begin
                    state_d    = GAP;
                    cnt_d      = '0;
                    cs_n_d     = 2'b11;
                    rx_data_d  = shreg;
                    rx_ch_d    = sel_q;
                    rx_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = SETUP;
            cnt_d   = '0;
            sel_d   = sel;
            cs_n_d  = sel ? 2'b01 : 2'b10;
            busy_d  = 1'b1;
            shreg_d = '0;
        end
    end

endmodule

// File: tb/tb_spi_master_adc.sv
// Randomized bench for spi_master_adc with a behavioural ADC slave pair
// and a frame-level reference model; instance 1 runs with CLK_DIV=5.
module tb_spi_master_adc;

    localparam int FB  = 16;
    localparam int LB  = 3;
    localparam int DW  = 8;
    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       st[2];
    logic       se[2];
    logic       bz[2];
    logic       sck[2];
    logic [1:0] csn[2];
    logic       sd[2];
    logic [7:0] rxd[2];
    logic       rxc[2];
    logic       rxv[2];

    logic [15:0] word[2][2];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    int nval[2], vcyc[2], falls[2], lfall[2], badh[2];
    int ovl[2], bfall[2], brise[2], gaprun[2], mingap[2];
    int seen_low[2];
    int csl[2][2];
    logic [7:0] vdat[2];
    logic vch[2];
    logic p_sck[2], p_bz[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master_adc dut_a (
        .clk(clk), .n_rst(n_rst), .start(st[0]), .sel(se[0]),
        .busy(bz[0]), .sclk(sck[0]), .cs_n(csn[0]), .sdata(sd[0]),
        .rx_data(rxd[0]), .rx_ch(rxc[0]), .rx_valid(rxv[0])
    );

    spi_master_adc #(.CLK_DIV(5)) dut_b (
        .clk(clk), .n_rst(n_rst), .start(st[1]), .sel(se[1]),
        .busy(bz[1]), .sclk(sck[1]), .cs_n(csn[1]), .sdata(sd[1]),
        .rx_data(rxd[1]), .rx_ch(rxc[1]), .rx_valid(rxv[1])
    );

    // Slave pair per master: load on cs fall, shift MSB first on sclk fall.
    for (genvar g = 0; g < 2; g++) begin : slv
        int idx = 0;
        logic bq = 1'b0;
        logic [15:0] w;
        always @(negedge sck[g] or negedge csn[g][0] or negedge csn[g][1]) begin
            if (sck[g]) begin
                idx = 0;
            end else if (csn[g] != 2'b11 && idx < 16) begin
                w = word[g][csn[g][0] ? 1 : 0];
                bq = w[15 - idx];
                idx++;
            end
        end
        assign sd[g] = (csn[g] != 2'b11) ? bq : 1'b0;
    end

    function automatic int div_of(input int g);
        return (g == 0) ? 2 : 5;
    endfunction

    function automatic int lat_of(input int g);
        return div_of(g) * (2 * FB + 2);
    endfunction

    // Frame layout: LB lead bits, DW data bits, trailing filler.
    function automatic logic [7:0] model_rx(input logic [15:0] w);
        logic [15:0] t;
        t = w >> (FB - LB - DW);
        return t[7:0];
    endfunction

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rxv[g]) begin
                nval[g]++;
                vcyc[g] = cyc;
                vdat[g] = rxd[g];
                vch[g]  = rxc[g];
            end
            if (p_sck[g] && !sck[g]) begin
                falls[g]++;
                lfall[g] = cyc;
            end
            if (!p_sck[g] && sck[g] && lfall[g] >= 0 &&
                cyc - lfall[g] != div_of(g)) badh[g]++;
            if (!csn[g][0]) csl[g][0]++;
            if (!csn[g][1]) csl[g][1]++;
            if (csn[g] == 2'b00) ovl[g]++;
            if (csn[g] == 2'b11) begin
                gaprun[g]++;
            end else begin
                if (seen_low[g] != 0 && gaprun[g] > 0 && gaprun[g] < mingap[g])
                    mingap[g] = gaprun[g];
                gaprun[g] = 0;
                seen_low[g] = 1;
            end
            if (p_bz[g] && !bz[g]) bfall[g] = cyc;
            if (!p_bz[g] && bz[g]) brise[g]++;
            p_sck[g] = sck[g];
            p_bz[g]  = bz[g];
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic run_frame(input int g, input logic s,
                             input logic [15:0] w, input logic [15:0] wo);
        int n0, f0, o0, t0, os;
        os = s ? 0 : 1;
        word[g][s ? 1 : 0] = w;
        word[g][os] = wo;
        n0 = nval[g];
        f0 = falls[g];
        o0 = csl[g][os];
        se[g] = s;
        st[g] = 1'b1;
        t0 = cyc + 1;
        tick;
        st[g] = 1'b0;
        for (int i = 0; i < 400 && nval[g] == n0; i++) tick;
        check("rx_valid_at", vcyc[g] - t0, lat_of(g));
        check("rx_data", vdat[g], model_rx(w));
        check("rx_ch", vch[g], s);
        for (int i = 0; i < 50 && bz[g]; i++) tick;
        check("busy_fall", bfall[g] - t0, lat_of(g) + GAP);
        check("rx_valid_len", nval[g] - n0, 1);
        check("sclk_falls", falls[g] - f0, FB);
        check("other_cs", csl[g][os] - o0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin : main
        int t0, n0, r0, prev;
        logic [7:0] ad[3];
        logic ac[3];
        ad = '{8'hC6, 8'hC7, 8'hC8};
        ac = '{1'b1, 1'b0, 1'b1};

        for (int g = 0; g < 2; g++) begin
            st[g] = 1'b0; se[g] = 1'b0;
            nval[g] = 0; vcyc[g] = 0; falls[g] = 0; lfall[g] = -1;
            badh[g] = 0; ovl[g] = 0; bfall[g] = 0; brise[g] = 0;
            gaprun[g] = 0; mingap[g] = 1000; seen_low[g] = 0;
            csl[g][0] = 0; csl[g][1] = 0;
            vdat[g] = '0; vch[g] = 1'b0;
            p_sck[g] = 1'b1; p_bz[g] = 1'b0;
            word[g][0] = '0; word[g][1] = '0;
        end

        n_rst = 1'b0;
        repeat (3) tick;
        check("rst_busy", bz[0], 0);
        check("rst_sclk", sck[0], 1);
        check("rst_cs_n", csn[0], 2'b11);
        check("rst_valid", rxv[0], 0);
        check("rst_rx_data", rxd[0], 0);
        check("rst_rx_ch", rxc[0], 0);
        n_rst = 1'b1;
        repeat (2) tick;

        run_frame(0, 1'b0, {3'b000, 8'hC5, 5'b00000}, 16'hFFFF);

        run_frame(0, 1'b0, {3'b111, 8'h00, 5'b11111}, 16'h5555);
        run_frame(0, 1'b1, {3'b000, 8'hFF, 5'b00000}, 16'hAAAA);

        for (int k = 0; k < 6; k++)
            run_frame(0, 1'($urandom_range(0, 1)), 16'($urandom),
                      16'($urandom));

        n0 = nval[0];
        word[0][1] = {3'b000, ad[0], 5'b00000};
        word[0][0] = 16'hFFFF;
        se[0] = ac[0];
        st[0] = 1'b1;
        t0 = cyc + 1;
        prev = t0;
        tick;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 200 && nval[0] == n0 + f; i++) tick;
            check("alt_period", vcyc[0] - prev, (f == 0) ? lat_of(0) : lat_of(0) + GAP);
            check("alt_data", vdat[0], ad[f]);
            check("alt_ch", vch[0], ac[f]);
            prev = vcyc[0];
            if (f < 2) begin
                se[0] = ac[f+1];
                word[0][ac[f+1] ? 1 : 0] = {3'b000, ad[f+1], 5'b00000};
            end else begin
                st[0] = 1'b0;
            end
        end
        repeat (150) tick;
        check("alt_count", nval[0] - n0, 3);
        check("cs_overlap", ovl[0], 0);
        check("cs_min_gap", mingap[0] >= GAP, 1);

        n0 = nval[0];
        r0 = brise[0];
        word[0][0] = {3'b110, 8'h5A, 5'b10101};
        se[0] = 1'b0;
        st[0] = 1'b1;
        t0 = cyc + 1;
        tick;
        st[0] = 1'b0;
        while (cyc < t0 + 9) tick;
        st[0] = 1'b1;
        tick;
        st[0] = 1'b0;
        while (cyc < t0 + 39) tick;
        st[0] = 1'b1;
        tick;
        st[0] = 1'b0;
        for (int i = 0; i < 200 && nval[0] == n0; i++) tick;
        check("ign_valid_at", vcyc[0] - t0, lat_of(0));
        check("ign_data", vdat[0], 8'h5A);
        for (int i = 0; i < 50 && bz[0]; i++) tick;
        check("ign_busy_fall", bfall[0] - t0, lat_of(0) + GAP);
        repeat (150) tick;
        check("ign_valid_cnt", nval[0] - n0, 1);
        check("ign_busy_rises", brise[0] - r0, 1);

        word[0][0] = {3'b000, 8'h3C, 5'b00000};
        se[0] = 1'b0;
        st[0] = 1'b1;
        t0 = cyc + 1;
        tick;
        st[0] = 1'b0;
        n0 = nval[0];
        while (cyc < t0 + 2 * 2 * 7) tick;
        n_rst = 1'b0;
        #1;
        check("abort_sclk", sck[0], 1);
        check("abort_cs_n", csn[0], 2'b11);
        check("abort_busy", bz[0], 0);
        check("abort_rx_data", rxd[0], 0);
        check("abort_valid", rxv[0], 0);
        repeat (3) tick;
        n_rst = 1'b1;
        repeat (100) tick;
        check("abort_no_valid", nval[0] - n0, 0);
        check("abort_idle", bz[0], 0);
        run_frame(0, 1'b0, {3'b011, 8'hA5, 5'b01101}, 16'($urandom));

        run_frame(1, 1'b0, {3'b000, 8'h96, 5'b00000}, 16'($urandom));
        run_frame(1, 1'b1, 16'($urandom), 16'($urandom));
        check("half_period_a", badh[0], 0);
        check("half_period_b", badh[1], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
